// File: rtl/seg7_scan_display_pkg.sv
// Shared constants for the multiplexed 7-segment front-panel driver.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package seg7_scan_display_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam int SCAN_DIV_SYN = 16;
   localparam int SCAN_DIV_SIM = 2;

   // Index 15 first so HEX_SEG[n] is the code for nibble n
   localparam logic [15:0][6:0] HEX_SEG = {
      7'h0E, 7'h06, 7'h21, 7'h46,
      7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19,
      7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/seg7_scan_display_hex_decode.sv
// Combinational nibble to active-low 7-segment code.
// Thin wrapper over the shared table.
module seg7_hex_decode
   import seg7_scan_display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed common-anode hex display driver.
// Snapshots value/dp_mask on load and scans one digit per prescaler wrap.
module seg7_scan_display
   import seg7_scan_display_pkg::*;
#(
   parameter int DIGITS        = 4,
   parameter int SCAN_DIV      = SCAN_DIV_SYN,
   parameter int BLANK_LEADING = 1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp_mask,
   input  logic                  load,
   output logic [DIGITS-1:0]     an,
   output logic [6:0]            seg,
   output logic                  dp
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

   logic [SCAN_DIV-1:0] cnt;
   logic                tick;
   logic [IW-1:0]       idx;
   logic [IW-1:0]       next_idx;
   logic [4*DIGITS-1:0] shadow_val;
   logic [DIGITS-1:0]   shadow_dp;

   logic [3:0]          sel_nib;
   logic                sel_dp;
   logic                sel_hi_zero;
   logic [DIGITS-1:0]   hi_zero;
   logic                blank;
   logic [6:0]          dec_seg;

   assign tick = &cnt;

   always_comb begin
      next_idx = idx;
      if (tick) begin
         next_idx = (idx == LAST) ? '0 : idx + 1'b1;
      end
   end

   // hi_zero[i]: every shadow nibble from i upward is zero
   always_comb begin
      logic z;
      z = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         z = z & (shadow_val[4*i +: 4] == 4'h0);
         hi_zero[i] = z;
      end
   end

   always_comb begin
      sel_nib     = '0;
      sel_dp      = 1'b0;
      sel_hi_zero = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (next_idx == IW'(i)) begin
            sel_nib     = shadow_val[4*i +: 4];
            sel_dp      = shadow_dp[i];
            sel_hi_zero = hi_zero[i];
         end
      end
   end

   assign blank = (BLANK_LEADING != 0) && (next_idx != '0)
                  && sel_hi_zero && !sel_dp;

   seg7_hex_decode u_dec (
      .nibble (sel_nib),
      .seg    (dec_seg)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
         idx <= LAST;
      end else begin
         cnt <= cnt + 1'b1;
         idx <= next_idx;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         shadow_val <= '0;
         shadow_dp  <= '0;
      end else if (load) begin
         shadow_val <= value;
         shadow_dp  <= dp_mask;
      end
   end

   // Decoded from the pre-load shadow, so load+tick shows old data
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         an  <= '1;
         seg <= SEG_BLANK;
         dp  <= 1'b1;
      end else if (tick) begin
         if (blank) begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
         end else begin
            an  <= ~(DIGITS'(1) << next_idx);
            seg <= dec_seg;
            dp  <= ~sel_dp;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench: three display instances against a behavioural model.
// Expected outputs are queued on each model tick and checked after the edge.
module tb_seg7_scan_display;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [15:0] value;
   logic [3:0]  dp_mask;
   logic        load;

   logic [3:0] an_a, an_b;
   logic [2:0] an_c;
   logic [6:0] seg_a, seg_b, seg_c;
   logic       dp_a, dp_b, dp_c;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [15:0] ea;
      logic [15:0] eb;
      logic [15:0] ec;
   } exp_t;

   exp_t q[$];
   int   mcnt;
   int   midx4;
   int   midx3;
   logic [15:0] ms_v;
   logic [3:0]  ms_d;

   always #5 clock = ~clock;

   seg7_scan_display #(.DIGITS(4), .SCAN_DIV(2), .BLANK_LEADING(1)) u_a (
      .clock(clock), .reset_n(reset_n), .value(value), .dp_mask(dp_mask),
      .load(load), .an(an_a), .seg(seg_a), .dp(dp_a));

   seg7_scan_display #(.DIGITS(4), .SCAN_DIV(2), .BLANK_LEADING(0)) u_b (
      .clock(clock), .reset_n(reset_n), .value(value), .dp_mask(dp_mask),
      .load(load), .an(an_b), .seg(seg_b), .dp(dp_b));

   seg7_scan_display #(.DIGITS(3), .SCAN_DIV(2), .BLANK_LEADING(1)) u_c (
      .clock(clock), .reset_n(reset_n), .value(value[11:0]),
      .dp_mask(dp_mask[2:0]), .load(load), .an(an_c), .seg(seg_c), .dp(dp_c));

   task automatic check(input string tag, input logic [15:0] got,
                        input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: return 7'h40; 4'h1: return 7'h79;
         4'h2: return 7'h24; 4'h3: return 7'h30;
         4'h4: return 7'h19; 4'h5: return 7'h12;
         4'h6: return 7'h02; 4'h7: return 7'h78;
         4'h8: return 7'h00; 4'h9: return 7'h10;
         4'hA: return 7'h08; 4'hB: return 7'h03;
         4'hC: return 7'h46; 4'hD: return 7'h21;
         4'hE: return 7'h06; default: return 7'h0E;
      endcase
   endfunction

   // Returns {an[7:0], seg[6:0], dp}
   function automatic logic [15:0] model(input int d, input bit bl,
      input int i, input logic [15:0] v, input logic [3:0] m);
      logic [7:0]  dmask;
      logic [15:0] vm;
      logic [7:0]  an8;
      dmask = 8'((1 << d) - 1);
      vm = v & 16'((32'h1 << (4 * d)) - 1);
      if (bl && i > 0 && !m[i] && ((vm >> (4 * i)) == 16'h0))
         return {dmask, 7'h7F, 1'b1};
      an8 = ~(8'd1 << i) & dmask;
      return {an8, hex7(4'(vm >> (4 * i))), ~m[i]};
   endfunction

   initial forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
         mcnt = 0; midx4 = 3; midx3 = 2;
         ms_v = '0; ms_d = '0;
         q.delete();
      end else begin
         if (mcnt == 3) begin
            exp_t e;
            midx4 = (midx4 == 3) ? 0 : midx4 + 1;
            midx3 = (midx3 == 2) ? 0 : midx3 + 1;
            e.ea = model(4, 1'b1, midx4, ms_v, ms_d);
            e.eb = model(4, 1'b0, midx4, ms_v, ms_d);
            e.ec = model(3, 1'b1, midx3, ms_v, ms_d);
            q.push_back(e);
         end
         if (load) begin
            ms_v = value;
            ms_d = dp_mask;
         end
         mcnt = (mcnt + 1) % 4;
      end
   end

   initial forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         check("d4_blank", {4'h0, an_a, seg_a, dp_a}, e.ea);
         check("d4_noblank", {4'h0, an_b, seg_b, dp_b}, e.eb);
         check("d3_blank", {5'h0, an_c, seg_c, dp_c}, e.ec);
      end
   end

   task automatic check_dark(input string tag);
      check({tag, "_a"}, {4'h0, an_a, seg_a, dp_a}, {8'h0F, 7'h7F, 1'b1});
      check({tag, "_b"}, {4'h0, an_b, seg_b, dp_b}, {8'h0F, 7'h7F, 1'b1});
      check({tag, "_c"}, {5'h0, an_c, seg_c, dp_c}, {8'h07, 7'h7F, 1'b1});
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] m);
      @(negedge clock);
      value = v; dp_mask = m; load = 1'b1;
      @(negedge clock);
      load = 1'b0;
   endtask

   task automatic run(input int n);
      repeat (n) @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      reset_n = 1'b0; value = '0; dp_mask = '0; load = 1'b0;
      run(3);
      check_dark("reset");
      reset_n = 1'b1;
      run(20);

      do_load(16'h12AF, 4'b0000);
      run(20);

      do_load(16'h0030, 4'b0000);
      run(16);

      do_load(16'h0005, 4'b0100);
      run(16);

      do_load(16'h1111, 4'b0000);
      run(8);
      seen = 0;
      for (int k = 0; k < 8 && !seen; k++) begin
         @(negedge clock);
         if (mcnt == 3) seen = 1;
      end
      check("tick_align", 16'(seen), 16'd1);
      value = 16'hFFFF; load = 1'b1;
      @(negedge clock);
      load = 1'b0;
      run(20);

      seen = 0;
      for (int k = 0; k < 64 && !seen; k++) begin
         @(negedge clock);
         if (an_a == 4'b1011) seen = 1;
      end
      check("midscan_seen", 16'(seen), 16'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check_dark("async_rst");
      @(negedge clock);
      reset_n = 1'b1;
      run(24);

      do_load(16'h0FED, 4'b0011);
      run(16);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
